threshold_monitor: RTL and testbench

- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Consumes a stream of WIDTH-bit samples and compares each against programmable high/low thresholds using greater/less/equal decisions.
- Applies debounce and hysteresis to drive a registered alarm with edge pulses, and tracks running max/min of accepted samples.
- Used wherever a comparator decision must be turned into a stable, glitch-free status flag.

---
 rtl/threshold_monitor.sv | 178 +++++++++++++++++
 tb/tb_threshold_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_monitor.sv
// threshold_monitor: debounced, hysteretic alarm on a sample stream.
// A sample above thresh_hi starts a rising streak and one below thresh_lo
// starts a falling streak. DEBOUNCE consecutive qualifiers change the alarm.
// Running max/min of accepted samples are tracked alongside the alarm.
module threshold_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] thresh_hi,
  input  logic [WIDTH-1:0] thresh_lo,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic             cfg_err,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic             have_sample
);

  typedef enum logic [1:0] {NORMAL, PEND_HI, ALARM, PEND_LO} state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cfg_q, cfg_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic             have_q, have_d;

  logic accept, above, below;

  assign accept = sample_valid & ~clear;
  assign above  = sample > thresh_hi;
  assign below  = sample < thresh_lo;
  assign cfg_d  = thresh_lo > thresh_hi;

  // Next-state logic for the debounce FSM and the streak counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (cfg_d) begin
      state_d = NORMAL;
      count_d = '0;
    end else if (accept) begin
      unique case (state_q)
        NORMAL: begin
          if (above) begin
            if (DEB == 4'd1) begin
              state_d = ALARM;
              count_d = '0;
            end else begin
              state_d = PEND_HI;
              count_d = 4'd1;
            end
          end
        end
        PEND_HI: begin
          if (above) begin
            if (count_q + 4'd1 >= DEB) begin
              state_d = ALARM;
              count_d = '0;
            end else begin
              count_d = count_q + 4'd1;
            end
          end else begin
            state_d = NORMAL;
            count_d = '0;
          end
        end
        ALARM: begin
          if (below) begin
            if (DEB == 4'd1) begin
              state_d = NORMAL;
              count_d = '0;
            end else begin
              state_d = PEND_LO;
              count_d = 4'd1;
            end
          end
        end
        PEND_LO: begin
          if (below) begin
            if (count_q + 4'd1 >= DEB) begin
              state_d = NORMAL;
              count_d = '0;
            end else begin
              count_d = count_q + 4'd1;
            end
          end else begin
            state_d = ALARM;
            count_d = '0;
          end
        end
        default: begin
          state_d = NORMAL;
          count_d = '0;
        end
      endcase
    end
  end

  // Alarm level follows the next state; edges compare against the current level.
  always_comb begin
    alarm_d = (state_d == ALARM) || (state_d == PEND_LO);
    rise_d  = alarm_d & ~alarm_q;
    fall_d  = alarm_q & ~alarm_d;
  end

  // Running max/min; the first accepted sample loads both.
  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    have_d = have_q;
    if (accept) begin
      have_d = 1'b1;
      if (!have_q) begin
        max_d = sample;
        min_d = sample;
      end else begin
        if (sample > max_q) max_d = sample;
        if (sample < min_q) min_d = sample;
      end
    end
  end

  // State registers; clear behaves as a synchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
      count_q <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cfg_q   <= 1'b0;
      max_q   <= '0;
      min_q   <= '1;
      have_q  <= 1'b0;
    end else if (clear) begin
      state_q <= NORMAL;
      count_q <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cfg_q   <= 1'b0;
      max_q   <= '0;
      min_q   <= '1;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cfg_q   <= cfg_d;
      max_q   <= max_d;
      min_q   <= min_d;
      have_q  <= have_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_rise  = rise_q;
  assign alarm_fall  = fall_q;
  assign cfg_err     = cfg_q;
  assign max_val     = max_q;
  assign min_val     = min_q;
  assign have_sample = have_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Testbench for threshold_monitor: hand-derived expectations pushed to a
// scoreboard as each stimulus cycle is driven, popped and checked after it.
module tb_threshold_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] sample = '0;
  logic [3:0] thresh_hi = 4'd10;
  logic [3:0] thresh_lo = 4'd4;

  logic       alarm, alarm_rise, alarm_fall, cfg_err, have_sample;
  logic [3:0] max_val, min_val;
  logic       alarm1, rise1, fall1, cfg1, have1;
  logic [3:0] max1, min1;

  int passed = 0;
  int total  = 0;

  // expected {alarm, alarm_rise, alarm_fall}
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  threshold_monitor #(.WIDTH(4), .DEBOUNCE(3)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .sample(sample), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
    .cfg_err(cfg_err), .max_val(max_val), .min_val(min_val),
    .have_sample(have_sample)
  );

  threshold_monitor #(.WIDTH(4), .DEBOUNCE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
    .sample(sample), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .alarm(alarm1), .alarm_rise(rise1), .alarm_fall(fall1),
    .cfg_err(cfg1), .max_val(max1), .min_val(min1),
    .have_sample(have1)
  );

  task automatic step(input logic v, input logic [3:0] s, input logic c);
    sample_valid = v;
    sample       = s;
    clear        = c;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    got = {alarm, alarm_rise, alarm_fall, cfg_err, max_val, min_val, have_sample};
    total++;
    if (got !== {4'b0000, 4'd0, 4'd15, 1'b0})
      $display("FAIL reset_state got %b want %b", got, {4'b0000, 4'd0, 4'd15, 1'b0});
    else passed++;
  endtask

  task automatic test_alarm_set();
    int         smp[4] = '{11, 12, 13, 0};
    logic       vld[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] ex[4]  = '{3'b000, 3'b000, 3'b110, 3'b100};
    logic [2:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      step(vld[i], 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm, alarm_rise, alarm_fall} !== e)
        $display("FAIL set[%0d] arf got %b want %b", i, {alarm, alarm_rise, alarm_fall}, e);
      else passed++;
    end
    total++;
    if ({max_val, min_val, have_sample} !== {4'd13, 4'd11, 1'b1})
      $display("FAIL set_maxmin got %0d/%0d/%b want 13/11/1", max_val, min_val, have_sample);
    else passed++;
  endtask

  task automatic test_broken_streak();
    int         smp[11] = '{11, 0, 12, 0, 7, 0, 11, 0, 12, 0, 14};
    logic [2:0] e;
    step(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back((i == 10) ? 3'b110 : 3'b000);
      step((i % 2) == 0, 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm, alarm_rise, alarm_fall} !== e)
        $display("FAIL streak[%0d] arf got %b want %b", i, {alarm, alarm_rise, alarm_fall}, e);
      else passed++;
    end
  endtask

  task automatic test_hysteresis();
    int         smp[6] = '{5, 10, 4, 3, 2, 1};
    logic [2:0] e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back((i == 5) ? 3'b001 : 3'b100);
      step(1'b1, 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm, alarm_rise, alarm_fall} !== e)
        $display("FAIL hyst[%0d] arf got %b want %b", i, {alarm, alarm_rise, alarm_fall}, e);
      else passed++;
    end
    total++;
    if ({max_val, min_val} !== {4'd14, 4'd1})
      $display("FAIL hyst_maxmin got %0d/%0d want 14/1", max_val, min_val);
    else passed++;
  endtask

  task automatic test_cfg_err();
    int         smp[3] = '{11, 12, 13};
    logic [2:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back((i == 2) ? 3'b110 : 3'b000);
      step(1'b1, 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm, alarm_rise, alarm_fall} !== e)
        $display("FAIL cfg_pre[%0d] arf got %b want %b", i, {alarm, alarm_rise, alarm_fall}, e);
      else passed++;
    end
    thresh_lo = 4'd9;
    thresh_hi = 4'd5;
    exp_q.push_back(3'b001);
    step(1'b0, 4'd0, 1'b0);
    e = exp_q.pop_front();
    total++;
    if ({cfg_err, alarm, alarm_rise, alarm_fall} !== {1'b1, e})
      $display("FAIL cfg_set got %b want %b", {cfg_err, alarm, alarm_rise, alarm_fall}, {1'b1, e});
    else passed++;
    exp_q.push_back(3'b000);
    step(1'b1, 4'd15, 1'b0);
    e = exp_q.pop_front();
    total++;
    if ({cfg_err, alarm, alarm_rise, alarm_fall, max_val} !== {1'b1, e, 4'd15})
      $display("FAIL cfg_track got %b want %b", {cfg_err, alarm, alarm_rise, alarm_fall, max_val},
               {1'b1, e, 4'd15});
    else passed++;
    thresh_lo = 4'd4;
    thresh_hi = 4'd10;
    step(1'b0, 4'd0, 1'b0);
    total++;
    if ({cfg_err, alarm} !== 2'b00)
      $display("FAIL cfg_restore got %b want 00", {cfg_err, alarm});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back((i == 2) ? 3'b110 : 3'b000);
      step(1'b1, 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm, alarm_rise, alarm_fall} !== e)
        $display("FAIL cfg_post[%0d] arf got %b want %b", i, {alarm, alarm_rise, alarm_fall}, e);
      else passed++;
    end
  endtask

  task automatic test_clear_priority();
    logic [12:0] got;
    step(1'b1, 4'd15, 1'b1);
    got = {alarm, alarm_rise, alarm_fall, cfg_err, max_val, min_val, have_sample};
    total++;
    if (got !== {4'b0000, 4'd0, 4'd15, 1'b0})
      $display("FAIL clear_state got %b want %b", got, {4'b0000, 4'd0, 4'd15, 1'b0});
    else passed++;
  endtask

  task automatic test_debounce1();
    int         smp[3] = '{11, 0, 3};
    logic       vld[3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] ex[3]  = '{3'b110, 3'b100, 3'b001};
    logic [2:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex[i]);
      step(vld[i], 4'(smp[i]), 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({alarm1, rise1, fall1} !== e)
        $display("FAIL deb1[%0d] arf got %b want %b", i, {alarm1, rise1, fall1}, e);
      else passed++;
    end
  endtask

  task automatic test_rst_midstreak();
    logic [2:0] e;
    step(1'b1, 4'd11, 1'b0);
    step(1'b1, 4'd12, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if ({alarm, alarm_rise, alarm_fall, max_val, min_val, have_sample} !== {3'b000, 4'd0, 4'd15, 1'b0})
      $display("FAIL rst_async got %b want %b",
               {alarm, alarm_rise, alarm_fall, max_val, min_val, have_sample}, {3'b000, 4'd0, 4'd15, 1'b0});
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(3'b000);
    step(1'b1, 4'd13, 1'b0);
    e = exp_q.pop_front();
    total++;
    if ({alarm, alarm_rise, alarm_fall, max_val, min_val, have_sample} !== {e, 4'd13, 4'd13, 1'b1})
      $display("FAIL rst_after got %b want %b",
               {alarm, alarm_rise, alarm_fall, max_val, min_val, have_sample}, {e, 4'd13, 4'd13, 1'b1});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alarm_set();
    test_broken_streak();
    test_hysteresis();
    test_cfg_err();
    test_clear_priority();
    test_debounce1();
    test_rst_midstreak();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
